// File: rtl/mmu_tile_loader.sv
// rtl/mmu_tile_loader.sv - serial element stream to parallel A/B/C matrices plus MMU enable handshake
// Optional feature macro: MMU_LOADER_SKIP_ACCUM_EN (adds accum_zero to skip the LOAD_C phase)
module mmu_tile_loader #(
  parameter int NUM_ROWS_A = 4,
  parameter int NUM_COLS_A = 4,
  parameter int NUM_COLS_B = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
`ifdef MMU_LOADER_SKIP_ACCUM_EN
  input  logic                                                  accum_zero,
`endif
  output logic                                                  busy,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                                 in_data,
  output logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] mat_a,
  output logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_b,
  output logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_c,
  output logic                                                  mmu_enable,
  input  logic                                                  mmu_data_ready,
  output logic                                                  done
);

  localparam int LEN_A   = NUM_ROWS_A * NUM_COLS_A;
  localparam int LEN_B   = NUM_COLS_A * NUM_COLS_B;
  localparam int LEN_C   = NUM_ROWS_A * NUM_COLS_B;
  localparam int MAX_AB  = (LEN_A > LEN_B) ? LEN_A : LEN_B;
  localparam int MAX_LEN = (MAX_AB > LEN_C) ? MAX_AB : LEN_C;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, RUN} state_e;

  state_e                                                state_q, state_d;
  logic [CNT_W-1:0]                                      cnt_q, cnt_d;
  logic                                                  done_q, done_d;
  logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] mat_a_q;
  logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_b_q;
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_c_q;
  logic                                                  beat;
  logic                                                  last_beat;
  logic [CNT_W-1:0]                                      phase_last;
  logic                                                  skip_c;

`ifdef MMU_LOADER_SKIP_ACCUM_EN
  logic skip_c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_c_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      skip_c_q <= accum_zero;
    end
  end

  assign skip_c = skip_c_q;
`else
  assign skip_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    phase_last = '0;
    case (state_q)
      LOAD_A:  phase_last = CNT_W'(LEN_A - 1);
      LOAD_B:  phase_last = CNT_W'(LEN_B - 1);
      LOAD_C:  phase_last = CNT_W'(LEN_C - 1);
      default: phase_last = '0;
    endcase
  end

  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (cnt_q == phase_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (beat) begin
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE:    if (start) state_d = LOAD_A;
      LOAD_A:  if (last_beat) state_d = LOAD_B;
      LOAD_B:  if (last_beat) state_d = skip_c ? RUN : LOAD_C;
      LOAD_C:  if (last_beat) state_d = RUN;
      RUN: begin
        if (mmu_data_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);
    mmu_enable = (state_q == RUN);
  end

  // Beat counter is the row-major element index within the current phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_a_q <= '0;
      mat_b_q <= '0;
      mat_c_q <= '0;
    end else begin
      if (beat && state_q == LOAD_A) begin
        for (int r = 0; r < NUM_ROWS_A; r++)
          for (int c = 0; c < NUM_COLS_A; c++)
            if (cnt_q == CNT_W'(r * NUM_COLS_A + c)) mat_a_q[r][c] <= in_data;
      end
      if (beat && state_q == LOAD_B) begin
        for (int r = 0; r < NUM_COLS_A; r++)
          for (int c = 0; c < NUM_COLS_B; c++)
            if (cnt_q == CNT_W'(r * NUM_COLS_B + c)) mat_b_q[r][c] <= in_data;
      end
      if (beat && state_q == LOAD_C) begin
        for (int r = 0; r < NUM_ROWS_A; r++)
          for (int c = 0; c < NUM_COLS_B; c++)
            if (cnt_q == CNT_W'(r * NUM_COLS_B + c)) mat_c_q[r][c] <= in_data;
      end
`ifdef MMU_LOADER_SKIP_ACCUM_EN
      if (state_q == IDLE && start && accum_zero) begin
        mat_c_q <= '0;
      end
`endif
    end
  end

  assign mat_a = mat_a_q;
  assign mat_b = mat_b_q;
  assign mat_c = mat_c_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mmu_tile_loader.sv
// tb/tb_mmu_tile_loader.sv - directed-vector bench for mmu_tile_loader
// Emulates the MMU data_ready response and checks matrices, handshake and control outputs.
module tb_mmu_tile_loader;

  localparam int R = 4;
  localparam int K = 4;
  localparam int N = 4;
  localparam int W = 16;

  typedef logic [3:0][3:0][15:0] mat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
`ifdef MMU_LOADER_SKIP_ACCUM_EN
  logic         accum_zero;
`endif
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  mat_t         mat_a;
  mat_t         mat_b;
  mat_t         mat_c;
  logic         mmu_enable;
  logic         mmu_data_ready;
  logic         done;

  mmu_tile_loader #(
    .NUM_ROWS_A(R),
    .NUM_COLS_A(K),
    .NUM_COLS_B(N),
    .DATA_WIDTH(W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
`ifdef MMU_LOADER_SKIP_ACCUM_EN
    .accum_zero    (accum_zero),
`endif
    .busy          (busy),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .mat_a         (mat_a),
    .mat_b         (mat_b),
    .mat_c         (mat_c),
    .mmu_enable    (mmu_enable),
    .mmu_data_ready(mmu_data_ready),
    .done          (done)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] elems[48];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mat_t pack(input int base);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = elems[base + r * 4 + c];
    return m;
  endfunction

  // Q8.8 multiply-accumulate as the MMU would compute it.
  function automatic mat_t mmu_result(input mat_t a, input mat_t b, input mat_t c);
    mat_t res;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic signed [31:0] acc;
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += 32'(signed'(a[i][k])) * 32'(signed'(b[k][j]));
        res[i][j] = 16'(acc >>> 8) + c[i][j];
      end
    return res;
  endfunction

  task automatic start_job(input bit az);
    @(posedge clk); #1;
    start = 1'b1;
`ifdef MMU_LOADER_SKIP_ACCUM_EN
    accum_zero = az;
`else
    if (az) $display("note: accum_zero ignored in this build");
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle, input int start_beat, output int ready_cnt);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b1;
    bit acc;
    bit pulsed = 1'b0;
    ready_cnt = 0;
    while (idx < n && guard < 400) begin
      in_valid = toggle ? ph : 1'b1;
      in_data  = elems[idx];
      start    = (idx == start_beat) && !pulsed;
      if (start) pulsed = 1'b1;
      @(negedge clk);
      if (in_ready) ready_cnt++;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      ph = ~ph;
      guard++;
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check_eq("stream_beats", 256'(idx), 256'(n));
  endtask

  task automatic run_mmu(input int start_at, output int en_cnt, output int done_cnt, output int lag);
    bit dr_sent = 1'b0;
    int dr_cyc = -100;
    int done_cyc = -100;
    en_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mmu_enable) en_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      @(posedge clk); #1;
      mmu_data_ready = (en_cnt == 2) && !dr_sent;
      if (mmu_data_ready) begin
        dr_sent = 1'b1;
        dr_cyc  = c + 1;
      end
      start = (c == start_at);
    end
    mmu_data_ready = 1'b0;
    start = 1'b0;
    lag = done_cyc - dr_cyc;
  endtask

  task automatic check_job(input string tag, input bit c_zero);
    mat_t exp_c;
    exp_c = c_zero ? '0 : pack(32);
    check_eq({tag, "_mat_a"}, mat_a, pack(0));
    check_eq({tag, "_mat_b"}, mat_b, pack(16));
    check_eq({tag, "_mat_c"}, mat_c, exp_c);
  endtask

  initial begin
    int rc, en, dn, lag;
    mat_t res;

    rst_n = 1'b0;
    start = 1'b0;
`ifdef MMU_LOADER_SKIP_ACCUM_EN
    accum_zero = 1'b0;
`endif
    in_valid = 1'b0;
    in_data = '0;
    mmu_data_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ctrl", {busy, in_ready, mmu_enable, done}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with start low: nothing moves.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("idle_ctrl", {busy, in_ready, mmu_enable, done}, 4'b0000);
    check_eq("idle_mat_a", mat_a, '0);
    check_eq("idle_mat_b", mat_b, '0);
    check_eq("idle_mat_c", mat_c, '0);

    // Identity job: A = I in Q8.8, B = 0..15, C = 0.
    for (int i = 0; i < 48; i++) elems[i] = '0;
    for (int i = 0; i < 4; i++) elems[i * 4 + i] = 16'h0100;
    for (int i = 0; i < 16; i++) elems[16 + i] = 16'(i);
    start_job(1'b0);
    @(negedge clk);
    check_eq("load_a_ctrl", {busy, in_ready, mmu_enable}, 3'b110);
    @(posedge clk); #1;
    stream(48, 1'b0, -1, rc);
    check_eq("ident_ready_cycles", 256'(rc), 256'(48));
    check_eq("ident_b12", 256'(mat_b[1][2]), 256'h0006);
    check_job("ident", 1'b0);
    run_mmu(-1, en, dn, lag);
    check_eq("ident_en_cycles", 256'(en), 256'(3));
    check_eq("ident_done_cnt", 256'(dn), 256'(1));
    check_eq("ident_done_lag", 256'(lag), 256'(1));
    res = mmu_result(mat_a, mat_b, mat_c);
    check_eq("ident_result", res, pack(16));
    check_eq("ident_idle", {busy, in_ready, mmu_enable, done}, 4'b0000);

    // Stalled stream: valid toggles every cycle.
    for (int i = 0; i < 48; i++) elems[i] = 16'hA000 + 16'(i);
    start_job(1'b0);
    stream(48, 1'b1, -1, rc);
    check_eq("stall_a33", 256'(mat_a[3][3]), 256'hA00F);
    check_eq("stall_c33", 256'(mat_c[3][3]), 256'hA02F);
    check_job("stall", 1'b0);
    run_mmu(-1, en, dn, lag);
    check_eq("stall_en_cycles", 256'(en), 256'(3));
    check_eq("stall_done_cnt", 256'(dn), 256'(1));

    // start pulsed during LOAD_B and during RUN is ignored.
    for (int i = 0; i < 48; i++) elems[i] = 16'h8000 + 16'(i * 7);
    start_job(1'b0);
    stream(48, 1'b0, 20, rc);
    check_eq("ign_ready_cycles", 256'(rc), 256'(48));
    check_job("ign", 1'b0);
    run_mmu(0, en, dn, lag);
    check_eq("ign_en_cycles", 256'(en), 256'(3));
    check_eq("ign_done_cnt", 256'(dn), 256'(1));
    @(negedge clk);
    check_eq("ign_idle", {busy, in_ready, mmu_enable, done}, 4'b0000);

    // Reset after 5 B beats aborts the job.
    for (int i = 0; i < 48; i++) elems[i] = 16'h3000 + 16'(i * 3);
    start_job(1'b0);
    stream(21, 1'b0, -1, rc);
    check_eq("abort_b00_written", 256'(mat_b[0][0]), 256'h3030);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ctrl", {busy, in_ready, mmu_enable, done}, 4'b0000);
    check_eq("abort_mat_a", mat_a, '0);
    check_eq("abort_mat_b", mat_b, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mmu(-1, en, dn, lag);
    check_eq("abort_no_done", 256'(dn), 256'(0));
    check_eq("abort_no_en", 256'(en), 256'(0));

    // Fresh job after the abort.
    for (int i = 0; i < 48; i++) elems[i] = 16'h5000 + 16'(i * 5);
    start_job(1'b0);
    stream(48, 1'b0, -1, rc);
    check_eq("fresh_ready_cycles", 256'(rc), 256'(48));
    check_job("fresh", 1'b0);
    run_mmu(-1, en, dn, lag);
    check_eq("fresh_en_cycles", 256'(en), 256'(3));
    check_eq("fresh_done_cnt", 256'(dn), 256'(1));

`ifdef MMU_LOADER_SKIP_ACCUM_EN
    // Skip LOAD_C: 32 beats, C cleared at start, RUN right after B[3][3].
    for (int i = 0; i < 48; i++) elems[i] = 16'h7000 + 16'(i);
    start_job(1'b1);
    check_eq("skip_c_cleared", mat_c, '0);
    stream(32, 1'b0, -1, rc);
    check_eq("skip_ready_cycles", 256'(rc), 256'(32));
    check_job("skip", 1'b1);
    run_mmu(-1, en, dn, lag);
    check_eq("skip_en_cycles", 256'(en), 256'(3));
    check_eq("skip_done_cnt", 256'(dn), 256'(1));
    accum_zero = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
